// File: rtl/cuckoo_pkg.sv
// Shared types for the cuckoo hash table and its insert queue.
// The table and the queue both use these, so their key and value widths always agree.
package cuckoo_pkg;

  localparam int KEY_W   = 8;
  localparam int VALUE_W = 12;

  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [VALUE_W-1:0] value_t;

  typedef struct packed {
    key_t   key;
    value_t value;
  } insert_req_t;

endpackage

// File: rtl/cuckoo_key_match.sv
// Combinational DEPTH-way key compare across the valid queue entries.
// When the head is leaving this cycle it is left out, so a request for its key becomes a new entry.
module cuckoo_key_match
  import cuckoo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  key_t             key_i,
  input  key_t [DEPTH-1:0] keys_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [IW-1:0]    headIdx_i,
  input  logic             excludeHead_i,
  output logic [DEPTH-1:0] match_o,
  output logic [IW-1:0]    idx_o,
  output logic             hit_o
);

  // At most one entry can hold a given key, so OR-ing the indices gives the encoded position.
  always_comb begin
    match_o = '0;
    idx_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_i[i] && (keys_i[i] == key_i) &&
                   !(excludeHead_i && (IW'(i) == headIdx_i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (match_o[i]) idx_o = idx_o | IW'(i);
    end
  end

  assign hit_o = |match_o;

endmodule

// File: rtl/cuckoo_insert_queue.sv
// In-order insert queue in front of the cuckoo table.
// A request whose key is already queued overwrites that entry's value.
module cuckoo_insert_queue
  import cuckoo_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int KEY_WIDTH   = KEY_W,
  parameter  int VALUE_WIDTH = VALUE_W,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [KEY_WIDTH-1:0]   in_key,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [KEY_WIDTH-1:0]   out_key,
  output logic [VALUE_WIDTH-1:0] out_value,
  output logic                   out_valid,
  input  logic                   insert_ready,
  input  logic                   flush,
  output logic [CW-1:0]          count,
  output logic                   coalesced
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [IW-1:0]    rdPtr_q, rdPtr_d;
  logic [IW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             coalesced_q, coalesced_d;
  insert_req_t      entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  insert_req_t      lastHead_q;

  key_t [DEPTH-1:0] keys;
  logic [DEPTH-1:0] matchVec;
  logic [IW-1:0]    matchIdx;
  logic             matchHit;
  logic             accept;
  logic             pop;
  logic             appendEn;
  logic             coalesceEn;

  assign in_ready  = (count_q != DEPTH_C) & ~flush;
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & insert_ready & ~flush;

  assign count     = count_q;
  assign coalesced = coalesced_q;

  // When the queue is empty, keep showing the last head instead of whatever slot rdPtr lands on.
  assign out_key   = out_valid ? entries_q[rdPtr_q].key   : lastHead_q.key;
  assign out_value = out_valid ? entries_q[rdPtr_q].value : lastHead_q.value;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) keys[i] = entries_q[i].key;
  end

  cuckoo_key_match #(
    .DEPTH(DEPTH)
  ) u_key_match (
    .key_i        (in_key),
    .keys_i       (keys),
    .valid_i      (valid_q),
    .headIdx_i    (rdPtr_q),
    .excludeHead_i(pop),
    .match_o      (matchVec),
    .idx_o        (matchIdx),
    .hit_o        (matchHit)
  );

  always_comb begin
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    coalesced_d = 1'b0;
    appendEn    = 1'b0;
    coalesceEn  = 1'b0;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pop) rdPtr_d = rdPtr_q + IW'(1);
      if (accept) begin
        if (matchHit) begin
          coalesceEn  = 1'b1;
          coalesced_d = 1'b1;
        end else begin
          appendEn = 1'b1;
          wrPtr_d  = wrPtr_q + IW'(1);
        end
      end
      case ({appendEn, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      coalesced_q <= 1'b0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      coalesced_q <= coalesced_d;
    end
  end

  // Pop and append never hit the same slot: that would need the queue to be both full and non-empty-accepting.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_q    <= '0;
      lastHead_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      if (out_valid) lastHead_q <= entries_q[rdPtr_q];
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (pop) valid_q[rdPtr_q] <= 1'b0;
        if (appendEn) begin
          entries_q[wrPtr_q] <= '{key: in_key, value: in_value};
          valid_q[wrPtr_q]   <= 1'b1;
        end
        if (coalesceEn) entries_q[matchIdx].value <= in_value;
      end
    end
  end

endmodule

// File: tb/tb_cuckoo_insert_queue.sv
// Directed and randomized checks of cuckoo_insert_queue against a queue-based reference model.
module tb_cuckoo_insert_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        areset;
  logic [7:0]  in_key;
  logic [11:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_key;
  logic [11:0] out_value;
  logic        out_valid;
  logic        insert_ready;
  logic        flush;
  logic [3:0]  count;
  logic        coalesced;

  cuckoo_insert_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .areset      (areset),
    .in_key      (in_key),
    .in_value    (in_value),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_key     (out_key),
    .out_value   (out_value),
    .out_valid   (out_valid),
    .insert_ready(insert_ready),
    .flush       (flush),
    .count       (count),
    .coalesced   (coalesced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  k;
    logic [11:0] v;
  } ent_t;

  ent_t modelQ[$];
  ent_t lastHead;
  bit   expCoal;
  bit   curFlush;
  int   checkCount = 0;
  int   passCount  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    modelQ.delete();
    lastHead = '{k: 8'h00, v: 12'h000};
    expCoal  = 1'b0;
  endtask

  // One clock edge of the queue, described as list operations on modelQ.
  task automatic modelStep(input bit iv, input logic [7:0] k, input logic [11:0] v,
                           input bit ir, input bit fl);
    bit popped;
    bit acc;
    int found;
    if (modelQ.size() > 0) lastHead = modelQ[0];
    expCoal = 1'b0;
    if (fl) begin
      modelQ.delete();
      return;
    end
    popped = ir && (modelQ.size() > 0);
    acc    = iv && (modelQ.size() < DEPTH);
    found  = -1;
    if (acc) begin
      for (int j = (popped ? 1 : 0); j < modelQ.size(); j++) begin
        if (modelQ[j].k == k) found = j;
      end
    end
    if (popped) begin
      void'(modelQ.pop_front());
      if (found > 0) found--;
    end
    if (acc) begin
      if (found >= 0) begin
        modelQ[found].v = v;
        expCoal = 1'b1;
      end else begin
        modelQ.push_back('{k: k, v: v});
      end
    end
  endtask

  task automatic checkOutput();
    ent_t shown;
    shown = (modelQ.size() > 0) ? modelQ[0] : lastHead;
    check("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
    check("out_key",   32'(out_key),   32'(shown.k));
    check("out_value", 32'(out_value), 32'(shown.v));
    check("count",     32'(count),     32'(modelQ.size()));
    check("in_ready",  32'(in_ready),  32'((modelQ.size() < DEPTH) && !curFlush));
    check("coalesced", 32'(coalesced), 32'(expCoal));
  endtask

  task automatic applyStimulus(input bit iv, input logic [7:0] k, input logic [11:0] v,
                               input bit ir, input bit fl);
    in_valid     = iv;
    in_key       = k;
    in_value     = v;
    insert_ready = ir;
    flush        = fl;
    curFlush     = fl;
    @(posedge clk);
    modelStep(iv, k, v, ir, fl);
    #1;
    checkOutput();
  endtask

  initial begin
    areset       = 1'b1;
    in_valid     = 1'b0;
    in_key       = '0;
    in_value     = '0;
    insert_ready = 1'b0;
    flush        = 1'b0;
    curFlush     = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput();
    areset = 1'b0;

    $display("[TB] single push into empty queue");
    applyStimulus(1, 8'h11, 12'h0AA, 0, 0);
    check("t1_key", 32'(out_key), 32'h11);
    check("t1_value", 32'(out_value), 32'h0AA);
    applyStimulus(0, 8'h00, 12'h000, 0, 1);

    $display("[TB] coalesce into queued key");
    applyStimulus(1, 8'h11, 12'h0AA, 0, 0);
    applyStimulus(1, 8'h22, 12'h0BB, 0, 0);
    applyStimulus(1, 8'h11, 12'h0CC, 0, 0);
    check("t2_coalesced", 32'(coalesced), 32'h1);
    check("t2_head_value", 32'(out_value), 32'h0CC);
    applyStimulus(0, 8'h00, 12'h000, 1, 0);
    check("t2_second_key", 32'(out_key), 32'h22);
    applyStimulus(0, 8'h00, 12'h000, 1, 0);

    $display("[TB] fill to full, then one pop");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h40 + i), 12'(12'h100 + i), 0, 0);
    check("t3_full_ready", 32'(in_ready), 32'h0);
    applyStimulus(1, 8'h99, 12'h999, 0, 0);
    applyStimulus(0, 8'h00, 12'h000, 1, 0);
    check("t3_reopen_ready", 32'(in_ready), 32'h1);
    applyStimulus(0, 8'h00, 12'h000, 0, 1);

    $display("[TB] push matching key while head pops");
    applyStimulus(1, 8'h33, 12'h001, 0, 0);
    applyStimulus(1, 8'h33, 12'h002, 1, 0);
    check("t4_value", 32'(out_value), 32'h002);
    applyStimulus(0, 8'h00, 12'h000, 0, 1);

    $display("[TB] continuous push and pop with pointer wrap");
    applyStimulus(1, 8'h80, 12'h080, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 8'(i), 12'(12'h200 + i), 1, 0);
    applyStimulus(0, 8'h00, 12'h000, 0, 1);

    $display("[TB] flush with coincident request, then async reset");
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h60 + i), 12'(12'h300 + i), 0, 0);
    applyStimulus(1, 8'h77, 12'h777, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h70 + i), 12'(12'h310 + i), 0, 0);
    in_valid = 1'b0;
    flush    = 1'b0;
    curFlush = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    areset = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 4) != 0),
                    8'($urandom_range(0, 11)),
                    12'($urandom),
                    ($urandom_range(0, 9) < 4),
                    ($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
